fpu_result_buffer: RTL

FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

---
 rtl/fpu_result_buffer_pkg.sv | 13 +
 rtl/fpu_result_buffer_sync_fifo.sv | 65 ++++++
 rtl/fpu_result_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/fpu_result_buffer_pkg.sv
// Shared FPU definitions: unit latencies, destination-tag width and the
// result record written back to the register file.
package fpu_result_buffer_pkg;

   localparam int FPU_LAT_ADDSUB = 1;
   localparam int FPU_TAGW       = 5;

   typedef struct packed {
      logic [FPU_TAGW-1:0] tag;
      logic [31:0]         data;
   } fpu_result_t;

endpackage

// File: rtl/fpu_result_buffer_sync_fifo.sv
// Synchronous FIFO with a registered head entry; a push into an empty (or
// emptying) FIFO loads the head register directly so it is visible next cycle.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_nxt;
   logic             do_push;
   logic             do_pop;

   assign out_valid = (count != '0);
   assign in_ready  = (count < CW'(DEPTH)) || (out_valid && out_ready);
   assign do_pop    = out_valid && out_ready && !flush;
   assign do_push   = in_valid && in_ready && !flush;
   assign rd_nxt    = rd_ptr + PW'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Occupancy after the pop is zero: the pushed entry becomes the head.
         if (do_push && (count == CW'(do_pop)))
            out_data <= in_data;
         else if (do_pop)
            out_data <= mem[rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/fpu_result_buffer.sv
// Credit-based result buffer for a fixed-latency, non-stallable FPU: tags
// travel alongside the unit, results land in a FIFO that drains to writeback.
module fpu_result_buffer
   import fpu_result_buffer_pkg::*;
#(
   parameter int LAT   = FPU_LAT_ADDSUB,
   parameter int DEPTH = 4,
   parameter int TAGW  = FPU_TAGW
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   issue_valid,
   input  logic [TAGW-1:0]        issue_tag,
   output logic                   issue_ready,
   input  logic                   flush,
   input  logic [31:0]            fpu_y,
   output logic                   wb_valid,
   output logic [TAGW-1:0]        wb_tag,
   output logic [31:0]            wb_data,
   input  logic                   wb_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);

   localparam int WIDTH = TAGW + 32;
   localparam int SW    = $clog2(DEPTH + LAT + 1) + 1;

   logic [LAT-1:0]   vld_p;
   logic [TAGW-1:0]  tag_p [LAT];
   logic [SW-1:0]    inflight;
   logic             accept;
   logic             fifo_in_ready;
   logic [WIDTH-1:0] head;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + SW'(vld_p[i]);
   end

   // Every accepted issue reserves a FIFO slot until its result is popped.
   assign issue_ready = (SW'(count) + inflight) < SW'(DEPTH);
   assign accept      = issue_valid && issue_ready && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p <= '0;
      end else if (flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_p[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err <= 1'b0;
      else if (!flush && vld_p[LAT-1] && !fifo_in_ready)
         err <= 1'b1;
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (vld_p[LAT-1]),
      .in_ready  (fifo_in_ready),
      .in_data   ({tag_p[LAT-1], fpu_y}),
      .out_valid (wb_valid),
      .out_ready (wb_ready),
      .out_data  (head),
      .count     (count)
   );

   assign wb_tag  = head[WIDTH-1 -: TAGW];
   assign wb_data = head[31:0];

endmodule
